// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder/subtractor
// One full-adder slice and a carry flop, reused LSB-first over WIDTH clocks.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             bit_s, bit_c, last;

  assign bit_s = a_sh[0] ^ b_sh[0] ^ c;
  assign bit_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
  assign last  = (cnt == CW'(WIDTH - 1));

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      s_sh     <= '0;
      c        <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: invert B and force the initial carry.
            a_sh <= a;
            b_sh <= sub ? ~b : b;
            c    <= sub ? 1'b1 : cin;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          s_sh <= {bit_s, s_sh[WIDTH-1:1]};
          c    <= bit_c;
          cnt  <= cnt + 1'b1;
          if (last) begin
            // On the MSB step c is still the carry into the MSB.
            sum      <= {bit_s, s_sh[WIDTH-1:1]};
            carry    <= bit_c;
            overflow <= c ^ bit_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor, the sequential successor to the single-bit full-adder cell. It captures two WIDTH-bit operands on a start pulse and processes them LSB-first through one full-adder slice and a carry flip-flop, one bit per clock. It reports sum, carry/no-borrow and signed overflow with a one-cycle done pulse. It serves area-constrained datapaths where one adder slice is reused over WIDTH cycles.

## Interface

- WIDTH, 8, operand/sum width in bits; legal range WIDTH >= 2
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- sub  input  1  0 = add (a + b + cin), 1 = subtract (a - b); sampled with start
- cin  input  1  carry-in for add; ignored when sub = 1
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse, result valid
- sum  output  WIDTH  result
- carry  output  1  carry-out of MSB; in subtract mode 1 = no borrow (a >= b unsigned)
- overflow  output  1  two's-complement overflow

## Operation

- States:
  - IDLE: waits for start.
  - RUN: processes WIDTH bit steps.
  - DONE: one cycle, then returns to IDLE.
- Capture, on the edge with state = IDLE and start = 1:
  - load shift register A <= a.
  - load shift register B <= (sub ? ~b : b).
  - carry flop <= (sub ? 1 : cin).
  - bit counter <= 0, state <= RUN.
- RUN step, each edge:
  - s = A[0] ^ B[0] ^ c.
  - c <= majority(A[0], B[0], c).
  - A and B shift right by one.
  - s shifts into the MSB of the internal sum shift register.
  - counter increments.
- Before the MSB step, i.e. counter = WIDTH-1, the current carry is latched as msb_cin.
- On the edge where counter = WIDTH-1:
  - state <= DONE.
  - sum output register <= final shifted sum.
  - carry <= final carry.
  - overflow <= msb_cin ^ final carry.
- DONE asserts done; the next edge returns to IDLE.
- start is ignored in RUN and in DONE. It is not queued, and a held start is not re-accepted until the state is IDLE.
- sum, carry and overflow update only on entry to DONE. They hold their value through later IDLE cycles and through the next operation's RUN.
- Arithmetic:
  - Add: the result is (a + b + cin) mod 2^WIDTH, and carry is bit WIDTH.
  - Subtract: the result is (a + ~b + 1) mod 2^WIDTH.

## Timing

- Reset (rst_n = 0 at an edge) gives:
  - state IDLE.
  - busy = 0, done = 0.
  - sum = 0, carry = 0, overflow = 0.
  - all shift registers and the counter cleared.
- Reset takes priority over every other event, including start on the same edge.
- Reset mid-RUN or in DONE abandons the operation: no done pulse, and outputs are cleared.
- Latency: with the capture at edge E0, the bit steps occur at edges E1..EWIDTH. done and the new outputs are visible in the cycle after edge EWIDTH, and done drops after edge EWIDTH+1.
- busy rises after E0 and falls after EWIDTH+1.
- Throughput: one operation per WIDTH+2 cycles. A new start is accepted at the earliest on the edge after done deasserts, i.e. in the first IDLE cycle.
- done is never high for more than one consecutive cycle.
- Operand inputs may change freely after the capture edge without affecting the result.

## Test plan

All scenarios use WIDTH = 8.

1. Reset then idle: rst_n low 2 cycles, then high, start = 0 -> sum = 8'h00, carry = 0, overflow = 0, busy = 0, done never asserts.
2. Add a = 8'h0F, b = 8'h01, cin = 0 -> done exactly 8 edges after capture; sum = 8'h10, carry = 0, overflow = 0. Repeat with a = 8'hFF, b = 8'h01, cin = 1 -> sum = 8'h01, carry = 1, overflow = 0.
3. Signed overflow: add a = 8'h7F, b = 8'h01, cin = 0 -> sum = 8'h80, carry = 0, overflow = 1.
4. Subtract:
   - a = 8'h05, b = 8'h07, sub = 1, cin = 1 (cin must be ignored) -> sum = 8'hFE, carry = 0, overflow = 0.
   - a = 8'h80, b = 8'h01 -> sum = 8'h7F, carry = 1, overflow = 1.
5. Handshake: hold start high continuously and change a/b during RUN -> the first result is unchanged. The second capture occurs on the first IDLE edge after done, giving exactly one done per WIDTH+2 cycles. Outputs hold their previous result during the second RUN.
6. Reset mid-operation: assert rst_n = 0 at the 4th RUN edge -> next cycle busy = 0, done = 0, sum/carry/overflow = 0, and no done pulse follows. A subsequent add of 8'h01 + 8'h01 yields sum = 8'h02.
